// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//   Multi-cycle access controller for a single shared asynchronous SRAM.
//   Two requesters, an instruction-fetch port (read only) and a data port
//   (read/write), are arbitrated. The winner's byte address becomes a word
//   address, and the SRAM strobes are sequenced over WAIT_CYCLES access cycles.
//   The winning port then gets its read data and a one-cycle acknowledge.
//
//   Sequence per access: IDLE (grant) -> ACCESS x WAIT_CYCLES -> DONE (ack).
//   Every output comes straight from a register.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   inst_req_i     instruction read request (level, held until inst_ack_o)
//   inst_addr_i    instruction byte address
//   inst_rdata_o   instruction read data (held until the next inst read)
//   inst_ack_o     one-cycle completion pulse for the instruction port
//   data_req_i     data request (level, held until data_ack_o)
//   data_we_i      1 = write, 0 = read
//   data_be_i      byte enables, active-high
//   data_addr_i    data byte address
//   data_wdata_i   data write data
//   data_rdata_o   data read data (held until the next data read)
//   data_ack_o     one-cycle completion pulse for the data port
//   sram_addr_o    SRAM word address
//   sram_wdata_o   SRAM write data
//   sram_rdata_i   SRAM read data
//   sram_ce_n_o    chip enable, active-low
//   sram_oe_n_o    output enable, active-low
//   sram_we_n_o    write enable, active-low
//   sram_be_n_o    byte enables, active-low
//
// WAIT_CYCLES must lie in 2..15. The first write cycle is reserved for address
// setup, and the wait counter is 4 bits wide.
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 32,
    parameter int WAIT_CYCLES   = 2,
    parameter int DATA_PRIORITY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req_i,
    input  logic [31:0]           inst_addr_i,
    output logic [DATA_W-1:0]     inst_rdata_o,
    output logic                  inst_ack_o,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [DATA_W/8-1:0]   data_be_i,
    input  logic [31:0]           data_addr_i,
    input  logic [DATA_W-1:0]     data_wdata_i,
    output logic [DATA_W-1:0]     data_rdata_o,
    output logic                  data_ack_o,
    output logic [ADDR_W-1:0]     sram_addr_o,
    output logic [DATA_W-1:0]     sram_wdata_o,
    input  logic [DATA_W-1:0]     sram_rdata_i,
    output logic                  sram_ce_n_o,
    output logic                  sram_oe_n_o,
    output logic                  sram_we_n_o,
    output logic [DATA_W/8-1:0]   sram_be_n_o
);

    localparam int          BE_W     = DATA_W / 8;
    localparam logic [3:0]  CNT_LAST = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_gnt_data;   // 1 = current access belongs to the data port
    logic                r_rr_data;    // 1 = data port wins the next round-robin tie
    logic                r_we;         // latched write flag of the current access
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_ce_n;
    logic                r_oe_n;
    logic                r_we_n;
    logic [BE_W-1:0]     r_be_n;
    logic                r_inst_ack;
    logic                r_data_ack;
    logic [DATA_W-1:0]   r_inst_rdata;
    logic [DATA_W-1:0]   r_data_rdata;

    logic                w_grant_data;
    logic                w_unused_addr;

    // Only bits [ADDR_W+1:2] of the byte addresses select a word.
    assign w_unused_addr = ^{inst_addr_i[31:ADDR_W+2], inst_addr_i[1:0],
                             data_addr_i[31:ADDR_W+2], data_addr_i[1:0]};

    // Port selection for a grant in IDLE. It only matters when a request is present.
    always_comb begin
        // NOTE: the default assignment comes first, so every path drives the
        // signal and no latch is inferred.
        w_grant_data = data_req_i;
        if (inst_req_i && data_req_i) begin
            w_grant_data = (DATA_PRIORITY != 0) ? 1'b1 : r_rr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_gnt_data   <= 1'b0;
            r_rr_data    <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_be_n       <= '1;
            r_inst_ack   <= 1'b0;
            r_data_ack   <= 1'b0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples values from before the edge.
            r_inst_ack <= 1'b0;
            r_data_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (inst_req_i || data_req_i) begin
                        r_state    <= ST_ACCESS;
                        r_cnt      <= '0;
                        r_gnt_data <= w_grant_data;
                        r_rr_data  <= ~w_grant_data;
                        r_ce_n     <= 1'b0;
                        r_we_n     <= 1'b1;   // first cycle is address setup
                        if (w_grant_data) begin
                            r_addr  <= data_addr_i[ADDR_W+1:2];
                            r_wdata <= data_wdata_i;
                            r_we    <= data_we_i;
                            r_be_n  <= ~data_be_i;
                            r_oe_n  <= data_we_i;
                        end else begin
                            r_addr  <= inst_addr_i[ADDR_W+1:2];
                            r_we    <= 1'b0;
                            r_be_n  <= '0;
                            r_oe_n  <= 1'b0;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_DONE;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_be_n  <= '1;
                        // Read data is sampled on the edge that leaves ACCESS.
                        if (!r_we) begin
                            if (r_gnt_data) r_data_rdata <= sram_rdata_i;
                            else            r_inst_rdata <= sram_rdata_i;
                        end
                        r_data_ack <= r_gnt_data;
                        r_inst_ack <= ~r_gnt_data;
                    end else begin
                        // After the setup cycle a write pulses we_n low until the end of the access.
                        r_we_n <= ~r_we;
                    end
                end
                ST_DONE: begin
                    // Address and write data stay put for hold time. No grant is made here.
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign inst_rdata_o = r_inst_rdata;
    assign inst_ack_o   = r_inst_ack;
    assign data_rdata_o = r_data_rdata;
    assign data_ack_o   = r_data_ack;
    assign sram_addr_o  = r_addr;
    assign sram_wdata_o = r_wdata;
    assign sram_ce_n_o  = r_ce_n;
    assign sram_oe_n_o  = r_oe_n;
    assign sram_we_n_o  = r_we_n;
    assign sram_be_n_o  = r_be_n;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Multi-cycle SRAM access controller that replaces the combinational address-pass-through stage between the CPU core and a single shared external SRAM.
- Accepts independent instruction-fetch and data-access requests.
- Translates byte addresses to word addresses, arbitrates between the two ports and sequences SRAM control strobes over a configurable number of wait cycles.
- Returns read data and a one-cycle acknowledge to the winning port.

Parameters:
- ADDR_W, 20, SRAM word-address width; word address = byte address bits [ADDR_W+1:2].
- DATA_W, 32, data width; must be a multiple of 8; BE_W = DATA_W/8.
- WAIT_CYCLES, 2, cycles spent in ACCESS state; legal range 2..15.
- DATA_PRIORITY, 1, 1 = data port always wins ties; 0 = round-robin on ties.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- inst_req_i  input  1  instruction read request, level, held until inst_ack_o
- inst_addr_i  input  32  instruction byte address
- inst_rdata_o  output  DATA_W  instruction read data
- inst_ack_o  output  1  one-cycle completion pulse
- data_req_i  input  1  data request, level, held until data_ack_o
- data_we_i  input  1  1 = write, 0 = read
- data_be_i  input  BE_W  byte enables, active-high
- data_addr_i  input  32  data byte address
- data_wdata_i  input  DATA_W  write data
- data_rdata_o  output  DATA_W  data read data
- data_ack_o  output  1  one-cycle completion pulse
- sram_addr_o  output  ADDR_W  SRAM word address
- sram_wdata_o  output  DATA_W  SRAM write data
- sram_rdata_i  input  DATA_W  SRAM read data
- sram_ce_n_o  output  1  chip enable, active-low
- sram_oe_n_o  output  1  output enable, active-low
- sram_we_n_o  output  1  write enable, active-low
- sram_be_n_o  output  BE_W  byte enables, active-low

Behaviour:
- Reset (rst low, asynchronous, takes effect immediately, including mid-access):
  - state = IDLE.
  - sram_ce_n_o, sram_oe_n_o and sram_we_n_o = 1; sram_be_n_o = all ones.
  - sram_addr_o = 0, sram_wdata_o = 0.
  - Both acks = 0; both rdata outputs = 0.
  - Round-robin pointer = instruction port.
  - An aborted access produces no ack.
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - If any request is high, grant one port and latch into registers: word address (byte address [ADDR_W+1:2]; upper bits and bits [1:0] ignored), write flag (inst port: always read), byte enables (inst port: all ones) and write data. Then go to ACCESS with wait counter = 0.
  - Tie with DATA_PRIORITY=1: data port wins.
  - Tie with DATA_PRIORITY=0: the port not granted last wins, and the pointer updates on every grant.
- ACCESS (WAIT_CYCLES cycles):
  - sram_ce_n_o = 0 and sram_be_n_o = ~latched BE for the whole state.
  - Read: sram_oe_n_o = 0 for the whole state. sram_rdata_i is sampled on the edge leaving ACCESS into the granted port's rdata register.
  - Write: sram_oe_n_o = 1. sram_we_n_o = 1 in the first ACCESS cycle (address setup) and 0 in the remaining cycles.
  - Counter increments each cycle; at WAIT_CYCLES-1 go to DONE.
- DONE (1 cycle):
  - All strobes deasserted; address and wdata held (hold time).
  - Granted port's ack = 1.
  - Unconditionally return to IDLE; no grant is made in DONE.
- Latency: request high at edge t (state IDLE) → ack high during cycle t+WAIT_CYCLES+1. Throughput is one access per WAIT_CYCLES+2 cycles.
- Read data stays valid from the ack cycle until that port's next read completes. Writes do not alter rdata.
- Requester must drop its request on the edge ending the ack cycle. Inputs are latched at grant; changes afterwards have no effect.
- A request dropped before its ack still completes, and the ack still pulses.
- Never assert both acks in the same cycle; never assert sram_oe_n_o and sram_we_n_o low together.

Test Plan:
- Inst read, WAIT_CYCLES=2, inst_addr_i=0x8000_0404, SRAM returns 0xDEADBEEF → sram_addr_o=0x00101, sram_oe_n_o low 2 cycles, inst_ack_o high 3 cycles after request, inst_rdata_o=0xDEADBEEF.
- Data write, addr 0x0000_0010, be=4'b0011, wdata=0x12345678 → sram_addr_o=0x00004, sram_be_n_o=4'b1100, sram_we_n_o high first ACCESS cycle then low, sram_oe_n_o stays high, data_ack_o pulse, data_rdata_o unchanged.
- Simultaneous inst+data requests, DATA_PRIORITY=1 → data served first, inst acked WAIT_CYCLES+2 cycles after data_ack_o.
- DATA_PRIORITY=0, both ports requesting continuously for 4 transactions → grants alternate I,D,I,D from reset; acks never overlap.
- rst driven low during the second ACCESS cycle of a write → sram_we_n_o and sram_ce_n_o return high immediately, no ack. After release, a new read completes normally.
- WAIT_CYCLES=4, data read → oe low exactly 4 cycles, ack in cycle t+5; the data value sampled at the last ACCESS edge is the value returned.
